// File: rtl/stack_op_sequencer.sv
// Stack operation sequencer: owns the architectural stack pointer and runs
// PUSH / POP / CALL / RET one at a time against a shared data-memory port.
// Full-descending stack: SP_RESET is the empty value, SP_LIMIT the lowest
// legal SP. The SP is committed only when the memory access completes.
module stack_op_sequencer #(
  parameter logic [31:0] SP_RESET = 32'd1023,
  parameter logic [31:0] SP_LIMIT = 32'd768
) (
  input  logic        clk,
  input  logic        rst,
  // execute-stage request
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_wdata,
  // direct SP load
  input  logic        sp_wr_en,
  input  logic [31:0] sp_wr_data,
  output logic [31:0] sp_out,
  // data-memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // response
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic [1:0]  resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_UNF     = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] sp_q, sp_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_fault_q, resp_fault_d;
  logic [1:0]  resp_err_q, resp_err_d;

  logic        push_class;
  logic        pop_class;
  logic [1:0]  fault_code;
  logic        accept;

  // A direct SP load wins over an operation request; nothing is accepted
  // while reset is held.
  assign op_ready = rst && (state_q == ST_IDLE) && !sp_wr_en;
  assign accept   = op_valid && op_ready;

  // Opcode decode and bounds check against the committed SP.
  always_comb begin
    push_class = (op_code == OP_PUSH) || (op_code == OP_CALL);
    pop_class  = (op_code == OP_POP)  || (op_code == OP_RET);
    fault_code = ERR_NONE;
    if (!push_class && !pop_class) begin
      fault_code = ERR_ILLEGAL;
    end else if (push_class && (sp_q == SP_LIMIT)) begin
      fault_code = ERR_OVF;
    end else if (pop_class && (sp_q == SP_RESET)) begin
      fault_code = ERR_UNF;
    end
  end

  // Next-state and next-output computation for the IDLE/MEM/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sp_wr_en) begin
          sp_d = sp_wr_data;
        end else if (accept) begin
          if (fault_code != ERR_NONE) begin
            // Faults skip memory entirely and leave SP untouched.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_err_d   = fault_code;
            resp_data_d  = 32'd0;
          end else begin
            // Address/data are latched here and held for the whole access.
            state_d   = ST_MEM;
            mem_req_d = 1'b1;
            if (push_class) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = sp_q - 32'd1;
              mem_wdata_d = op_wdata;
            end else begin
              mem_we_d    = 1'b0;
              mem_addr_d  = sp_q;
              mem_wdata_d = 32'd0;
            end
          end
        end
      end

      ST_MEM: begin
        if (mem_ack) begin
          // Completion: commit SP and build the response in one step.
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_err_d   = ERR_NONE;
          if (mem_we_q) begin
            sp_d        = sp_q - 32'd1;
            resp_data_d = 32'd0;
          end else begin
            sp_d        = sp_q + 32'd1;
            resp_data_d = mem_rdata;
          end
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        mem_req_d    = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sp_q         <= SP_RESET;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_fault_q <= 1'b0;
      resp_err_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign sp_out     = sp_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench for stack_op_sequencer: a transaction-level stack model
// (SP value plus a sparse memory image) predicts every access and response;
// one compare process checks the DUT against it on every falling edge.
module tb_stack_op_sequencer;

  localparam logic [31:0] SP_RESET = 32'd1023;
  localparam logic [31:0] SP_LIMIT = 32'd768;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready;
  logic [2:0]  op_code;
  logic [31:0] op_wdata;
  logic        sp_wr_en;
  logic [31:0] sp_wr_data, sp_out;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;

  stack_op_sequencer #(.SP_RESET(SP_RESET), .SP_LIMIT(SP_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_wdata(op_wdata),
    .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data), .sp_out(sp_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_fault(resp_fault), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: which phase the current transaction is in, and what it owes.
  typedef enum {PH_IDLE, PH_MEM, PH_RESP} phase_t;
  phase_t      phase = PH_IDLE;
  bit          chk_en = 1'b0;
  logic [31:0] m_sp = SP_RESET;
  logic [31:0] mem_m [logic [31:0]];
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_fault = 1'b0;
  logic [1:0]  exp_err = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sp_out", sp_out, m_sp);
      chk("op_ready", 32'(op_ready), 32'((phase == PH_IDLE) && !sp_wr_en));
      chk("mem_req", 32'(mem_req), 32'(phase == PH_MEM));
      if (phase == PH_MEM) begin
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", mem_addr, exp_addr);
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("resp_valid", 32'(resp_valid), 32'(phase == PH_RESP));
      if (phase == PH_RESP) begin
        chk("resp_data", resp_data, exp_rdata);
        chk("resp_fault", 32'(resp_fault), 32'(exp_fault));
        chk("resp_err", 32'(resp_err), 32'(exp_err));
      end
    end
  end

  // Direct SP load from IDLE; takes effect on the next edge.
  task automatic sp_load(input logic [31:0] v);
    sp_wr_en = 1'b1;
    sp_wr_data = v;
    @(posedge clk); #1;
    m_sp = v;
    sp_wr_en = 1'b0;
  endtask

  // One full operation: present, access memory (if legal), drain response.
  // Called and returns at posedge+1 with the DUT idle.
  task automatic do_op(input logic [2:0] c, input logic [31:0] w, input int ack_wait,
                       input int rdy_wait, input bit noise,
                       output logic [31:0] r_data, output logic r_fault, output logic [1:0] r_err);
    logic push_c, pop_c;
    logic [31:0] rd;
    push_c = (c == 3'd1) || (c == 3'd3);
    pop_c  = (c == 3'd2) || (c == 3'd4);
    exp_fault = 1'b1;
    exp_rdata = 32'd0;
    exp_err = 2'b00;
    if (!push_c && !pop_c) exp_err = 2'b11;
    else if (push_c && m_sp == SP_LIMIT) exp_err = 2'b01;
    else if (pop_c && m_sp == SP_RESET) exp_err = 2'b10;
    else exp_fault = 1'b0;
    sp_wr_en = 1'b0;
    op_valid = 1'b1;
    op_code = c;
    op_wdata = w;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (!exp_fault) begin
      exp_we = push_c;
      exp_addr = push_c ? m_sp - 32'd1 : m_sp;
      exp_wdata = w;
      rd = mem_m.exists(exp_addr) ? mem_m[exp_addr] : $urandom;
      phase = PH_MEM;
      for (int i = 0; i <= ack_wait; i++) begin
        mem_ack = (i == ack_wait);
        mem_rdata = (i == ack_wait) ? rd : $urandom;
        if (noise) begin
          sp_wr_en = 1'($urandom);
          sp_wr_data = $urandom;
          op_valid = 1'($urandom);
          op_code = 3'($urandom);
        end
        @(posedge clk); #1;
      end
      if (push_c) begin
        mem_m[exp_addr] = w;
        m_sp = m_sp - 32'd1;
        exp_rdata = 32'd0;
      end else begin
        m_sp = m_sp + 32'd1;
        exp_rdata = rd;
      end
    end
    phase = PH_RESP;
    r_data = 32'd0;
    r_fault = 1'b0;
    r_err = 2'b00;
    for (int i = 0; i <= rdy_wait; i++) begin
      resp_ready = (i == rdy_wait);
      mem_ack = 1'b0;
      if (noise) begin
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        sp_wr_en = 1'($urandom);
        sp_wr_data = $urandom;
        op_valid = 1'($urandom);
      end
      @(negedge clk);
      r_data = resp_data;
      r_fault = resp_fault;
      r_err = resp_err;
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    mem_ack = 1'b0;
    sp_wr_en = 1'b0;
    op_valid = 1'b0;
    phase = PH_IDLE;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic f;
    logic [1:0] e;
    logic [2:0] ill [4];
    logic [31:0] sp_pick [6];
    ill = '{3'd0, 3'd5, 3'd6, 3'd7};

    rst = 1'b1;
    op_valid = 1'b0; op_code = 3'd0; op_wdata = 32'd0;
    sp_wr_en = 1'b0; sp_wr_data = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; resp_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset_sp", sp_out, 32'd1023);
    chk("reset_op_ready", 32'(op_ready), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_resp_fault", 32'(resp_fault), 32'd0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // PUSH 0xDEADBEEF, ack in the second MEM cycle.
    do_op(3'd1, 32'hDEADBEEF, 1, 0, 1'b0, d, f, e);
    chk("push_addr_model", exp_addr, 32'd1022);
    chk("push_fault", 32'(f), 32'd0);
    chk("push_sp", sp_out, 32'd1022);
    $display("txn PUSH data=deadbeef sp=%0d fault=%0d", sp_out, f);

    // POP with same-cycle ack returns the pushed value.
    do_op(3'd2, 32'd0, 0, 0, 1'b0, d, f, e);
    chk("pop_addr_model", exp_addr, 32'd1022);
    chk("pop_data", d, 32'hDEADBEEF);
    chk("pop_sp", sp_out, 32'd1023);
    $display("txn POP data=%h sp=%0d", d, sp_out);

    // Underflow on empty stack.
    do_op(3'd2, 32'd0, 0, 0, 1'b0, d, f, e);
    chk("unf_fault", 32'(f), 32'd1);
    chk("unf_err", 32'(e), 32'd2);
    chk("unf_sp", sp_out, 32'd1023);
    $display("txn POP-empty fault=%0d err=%0d", f, e);

    // Overflow: CALL at the limit.
    sp_load(32'd768);
    do_op(3'd3, 32'h100, 0, 0, 1'b0, d, f, e);
    chk("ovf_fault", 32'(f), 32'd1);
    chk("ovf_err", 32'(e), 32'd1);
    chk("ovf_sp", sp_out, 32'd768);
    $display("txn CALL-at-limit fault=%0d err=%0d", f, e);

    // Illegal opcode.
    do_op(3'd7, 32'h0, 0, 1, 1'b0, d, f, e);
    chk("ill_fault", 32'(f), 32'd1);
    chk("ill_err", 32'(e), 32'd3);
    chk("ill_data", d, 32'd0);
    $display("txn OP7 fault=%0d err=%0d", f, e);

    // SP load and op request in the same cycle: load wins, op waits a cycle.
    sp_wr_en = 1'b1; sp_wr_data = 32'd900;
    op_valid = 1'b1; op_code = 3'd1; op_wdata = 32'h1234;
    @(negedge clk);
    chk("prio_op_ready", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    m_sp = 32'd900;
    sp_wr_en = 1'b0;
    chk("prio_sp", sp_out, 32'd900);
    do_op(3'd1, 32'h1234, 0, 0, 1'b0, d, f, e);
    chk("prio_push_sp", sp_out, 32'd899);
    $display("txn SPLOAD+PUSH sp=%0d", sp_out);

    // CALL then RET with a slow consumer.
    do_op(3'd3, 32'h40, 2, 3, 1'b0, d, f, e);
    chk("call_sp", sp_out, 32'd898);
    do_op(3'd4, 32'd0, 1, 3, 1'b0, d, f, e);
    chk("ret_data", d, 32'h40);
    chk("ret_sp", sp_out, 32'd899);
    $display("txn CALL/RET data=%h sp=%0d", d, sp_out);

    // Randomized traffic with noise on ignored inputs.
    sp_pick = '{32'd768, 32'd769, 32'd770, 32'd1022, 32'd1023, 32'd0};
    for (int n = 0; n < 300; n++) begin
      int sel;
      logic [2:0] c;
      logic [31:0] w;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        w = sp_pick[$urandom_range(0, 5)];
        if (w == 32'd0) w = $urandom;
        sp_load(w);
        $display("txn SPLOAD sp=%h", w);
      end else begin
        sel = int'($urandom_range(0, 9));
        if (sel < 4) c = (sel < 2) ? 3'd1 : 3'd3;
        else if (sel < 8) c = (sel < 6) ? 3'd2 : 3'd4;
        else c = ill[$urandom_range(0, 3)];
        w = $urandom;
        do_op(c, w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, d, f, e);
        $display("txn op=%0d wdata=%h resp=%h fault=%0d err=%0d sp=%h", c, w, d, f, e, sp_out);
      end
    end

    // Reset in the middle of a memory access.
    sp_load(32'd1000);
    exp_we = 1'b1; exp_addr = 32'd999; exp_wdata = 32'hCAFE;
    op_valid = 1'b1; op_code = 3'd1; op_wdata = 32'hCAFE;
    @(posedge clk); #1;
    op_valid = 1'b0;
    mem_ack = 1'b0;
    phase = PH_MEM;
    @(negedge clk);
    #2;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_sp", sp_out, 32'd1023);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    m_sp = SP_RESET;
    phase = PH_IDLE;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555AAAA;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    $display("txn RESET-in-MEM sp=%0d mem_req=%0d", sp_out, mem_req);

    // Normal operation resumes after reset.
    do_op(3'd1, 32'h0BADF00D, 0, 0, 1'b0, d, f, e);
    do_op(3'd2, 32'd0, 0, 0, 1'b0, d, f, e);
    chk("post_rst_pop", d, 32'h0BADF00D);
    chk("post_rst_sp", sp_out, 32'd1023);
    $display("txn PUSH/POP after reset data=%h sp=%0d", d, sp_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
